instr_encode: RTL and testbench
===============================

// Module: instr_encode
// PURPOSE
//  Inverse of the core's field decoder: packs opcode/func3/func7/Rs1/Rs2/Rd/imme fields into 32-bit RV32I
//  instruction words, range-checks the immediate per format and writes each word to instruction memory.
//  Sits between a test/boot program source (valid/ready field stream) and the IMEM write port.
//  Stops at EBREAK, on a bad field/immediate, or when MAX_WORDS words have been written.
// PARAMETERS
//  BASE_ADDR  32'h0000_0000  byte address of first word written
//  MAX_WORDS  1024           capacity in words; must be >=1
//  CNT_W      11             width of count; holds 0..MAX_WORDS
// PORTS
//  clk        in   1      single clock, all state on posedge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      pulse: begin new load at BASE_ADDR (honoured in IDLE/DONE only)
//  in_valid   in   1      field bundle valid
//  in_ready   out  1      encoder accepts bundle this cycle
//  opcode     in   7      instr[6:0]
//  func3      in   3      instr[14:12]
//  func7      in   1      value for instr[30] (R-type, SRAI/SRLI select)
//  Rs1,Rs2,Rd in   5 each instr[19:15], instr[24:20], instr[11:7]
//  imme       in   32     full sign-extended immediate (byte offset for B/J, upper value for U)
//  mem_we     out  1      IMEM write strobe, one cycle per word
//  mem_addr   out  32     byte address of word
//  mem_wdata  out  32     encoded instruction
//  busy       out  1      state==RUN
//  done       out  1      state==DONE
//  err        out  1      sticky: load aborted (bad immediate, unknown opcode or capacity)
//  count      out  CNT_W  words written since last start
// BEHAVIOUR
//  Reset: state IDLE; in_ready,mem_we,busy,done,err=0; mem_addr=BASE_ADDR; mem_wdata=0; count=0.
//  FSM IDLE -start-> RUN; RUN -(ebreak accepted | error | count reaches MAX_WORDS)-> DONE; DONE -start-> RUN.
//  start in RUN ignored. On start: count=0, err=0, done=0.
//  in_ready = (state==RUN). Accept = in_valid & in_ready. No IMEM backpressure.
//  Latency 1: bundle accepted at edge N -> mem_we=1 in cycle N+1 with mem_addr=BASE_ADDR+4*count(old), count+1.
//  Encoding by opcode (imm bit placement exact inverse of the core decoder):
//   0110011 R: {1'b0,func7,5'b0,Rs2,Rs1,func3,Rd,op}; imme ignored.
//   0010011 I-ALU: {imme[11:0],Rs1,func3,Rd,op}; if func3=001/101: [31:25]={1'b0,func7,5'b0},[24:20]=imme[4:0].
//   0000011 load, 1100111 jalr: I format as above (no shift special case).
//   0100011 S: {imme[11:5],Rs2,Rs1,func3,imme[4:0],op}.
//   1100011 B: {imme[12],imme[10:5],Rs2,Rs1,func3,imme[4:1],imme[11],op}.
//   0110111 lui, 0010111 auipc: {imme[31:12],Rd,op}.
//   1101111 jal: {imme[20],imme[10:1],imme[11],imme[19:12],Rd,op}.
//   1110011 system: word forced to 32'h00100073 (EBREAK), other fields ignored.
//  Range checks (fail -> error): I/S imme[31:11] all equal; shift imme[31:5]==0; B imme[31:12] equal and imme[0]==0;
//   J imme[31:20] equal and imme[0]==0; U imme[11:0]==0; any other opcode -> error.
//  Error: word NOT written, count unchanged, err=1, state->DONE at same edge; in_ready low from next cycle.
//  EBREAK: word written at N+1, done=1 at N+1 (same edge as state->DONE).
//  Capacity: the accept that makes count==MAX_WORDS is written normally, then DONE with err=0;
//   err is set only if... never: DONE via capacity leaves err=0 unless that last word was itself bad.
//  mem_we deasserts the cycle after each write; mem_addr/mem_wdata hold last value.
//  rst mid-RUN: pending write dropped (mem_we=0 next cycle), all outputs to reset values.
// TESTING
//  start; addi x1,x0,5 (op 13,f3 0,Rd 1,imme 5) -> mem_we @BASE+0 data 0x00500093, count=1.
//  sw x2,8(x1) then beq x0,x0,-4 back-to-back -> 0x0020A423 @+4, 0xFE000EE3 @+8, mem_we 2 consecutive cycles.
//  srai x3,x3,2 (f3 5,func7 1) -> 0x4021D193; lui x5,imme 0x12345000 -> 0x123452B7.
//  jal x1 imme 0x00000101 (odd) -> no write, err=1, done=1, in_ready=0, count unchanged.
//  ebreak after 3 words -> 0x00100073 @+12, done=1, count=4; further in_valid not accepted; start clears done/count.
//  MAX_WORDS=2: 3 valid addi -> 2 writes, done=1 err=0; rst asserted the cycle after an accept -> no mem_we, count=0.

Source files
------------

// File: rtl/instr_encode.sv
// instr_encode
//   Packs RV32I instruction fields into 32-bit words and writes them to
//   instruction memory. It is the exact inverse of the core's field decoder.
//   A load session runs from start until one of three things happens:
//   EBREAK is written, a bad field or immediate is seen, or MAX_WORDS words
//   have been written.
//
// Handshake: a bundle transfers on a rising edge where in_valid && in_ready.
//   in_ready depends only on state, never on in_valid. A producer holding
//   in_valid high must keep its fields stable until the transfer edge.
//   The IMEM write port has no backpressure.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   start                         begin a new load (ignored while RUN)
//   in_valid / in_ready           field bundle handshake
//   opcode func3 func7 Rs1 Rs2 Rd imme   instruction fields
//   mem_we mem_addr mem_wdata     IMEM write port, one strobe per word
//   busy / done / err             RUN, DONE, sticky abort flag
//   count                         words written since last start
//   dbg_state                     raw FSM state (0 IDLE, 1 RUN, 2 DONE)

module instr_encode #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024,
    parameter int          CNT_W     = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic             func7,
    input  logic [4:0]       Rs1,
    input  logic [4:0]       Rs2,
    input  logic [4:0]       Rd,
    input  logic [31:0]      imme,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       dbg_state
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic        accept;
    logic        start_ok;
    logic        count_last;
    logic [31:0] enc_word;
    logic        enc_bad;
    logic        enc_ebreak;

    // The immediate range checks: the upper bits must be a pure sign
    // extension, and branch or jump offsets must be even.
    logic i_ok, b_ok, j_ok, u_ok, sh_ok;

    assign i_ok  = (&imme[31:11]) | ~(|imme[31:11]);
    assign b_ok  = ((&imme[31:12]) | ~(|imme[31:12])) & ~imme[0];
    assign j_ok  = ((&imme[31:20]) | ~(|imme[31:20])) & ~imme[0];
    assign u_ok  = ~(|imme[11:0]);
    assign sh_ok = ~(|imme[31:5]);

    assign accept     = in_valid & in_ready;
    assign start_ok   = start & (state != S_RUN);
    assign count_last = (count == CNT_W'(MAX_WORDS - 1));

    // Field packing
    always_comb begin
        enc_word   = '0;
        enc_bad    = 1'b0;
        enc_ebreak = 1'b0;
        case (opcode)
            OP_R: begin
                enc_word = {1'b0, func7, 5'b0, Rs2, Rs1, func3, Rd, opcode};
            end
            OP_IALU: begin
                // SLLI/SRLI/SRAI: the shamt replaces imm[4:0], and func7
                // selects arithmetic versus logical in bit 30.
                if (func3 == 3'b001 || func3 == 3'b101) begin
                    enc_word = {1'b0, func7, 5'b0, imme[4:0], Rs1, func3, Rd, opcode};
                    enc_bad  = ~sh_ok;
                end else begin
                    enc_word = {imme[11:0], Rs1, func3, Rd, opcode};
                    enc_bad  = ~i_ok;
                end
            end
            OP_LOAD, OP_JALR: begin
                enc_word = {imme[11:0], Rs1, func3, Rd, opcode};
                enc_bad  = ~i_ok;
            end
            OP_STORE: begin
                enc_word = {imme[11:5], Rs2, Rs1, func3, imme[4:0], opcode};
                enc_bad  = ~i_ok;
            end
            OP_BRANCH: begin
                enc_word = {imme[12], imme[10:5], Rs2, Rs1, func3,
                            imme[4:1], imme[11], opcode};
                enc_bad  = ~b_ok;
            end
            OP_LUI, OP_AUIPC: begin
                enc_word = {imme[31:12], Rd, opcode};
                enc_bad  = ~u_ok;
            end
            OP_JAL: begin
                enc_word = {imme[20], imme[10:1], imme[11], imme[19:12], Rd, opcode};
                enc_bad  = ~j_ok;
            end
            OP_SYSTEM: begin
                // Any system opcode is emitted as EBREAK and ends the load.
                enc_word   = EBREAK_WORD;
                enc_ebreak = 1'b1;
            end
            default: begin
                enc_bad = 1'b1;
            end
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM: next state
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_RUN;
            S_RUN: begin
                // A bad word, EBREAK, and the final in-capacity word all
                // leave RUN at the edge where the bundle is accepted.
                if (accept && (enc_bad || enc_ebreak || count_last)) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: if (start) state_nx = S_RUN;
            default: state_nx = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state == S_RUN);
        busy      = (state == S_RUN);
        done      = (state == S_DONE);
        dbg_state = state;
    end

    // Write port, count and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
            err       <= 1'b0;
            count     <= '0;
        end else begin
            mem_we <= 1'b0;
            if (start_ok) begin
                count <= '0;
                err   <= 1'b0;
            end else if (accept) begin
                if (enc_bad) begin
                    err <= 1'b1;
                end else begin
                    mem_we    <= 1'b1;
                    mem_addr  <= BASE_ADDR + (32'(count) << 2);
                    mem_wdata <= enc_word;
                    count     <= count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encode.sv
module tb_instr_encode;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start2;
    logic        rst2;
    logic        in_valid;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        func7;
    logic [4:0]  Rs1, Rs2, Rd;
    logic [31:0] imme;

    logic        in_ready, mem_we, busy, done, err;
    logic [31:0] mem_addr, mem_wdata;
    logic [10:0] count;
    logic [1:0]  dbg_state;

    logic        in_ready2, mem_we2, busy2, done2, err2;
    logic [31:0] mem_addr2, mem_wdata2;
    logic [1:0]  count2;
    logic [1:0]  dbg_state2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_encode dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .opcode(opcode), .func3(func3), .func7(func7),
        .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .imme(imme),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .count(count),
        .dbg_state(dbg_state)
    );

    instr_encode #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .in_valid(in_valid),
        .in_ready(in_ready2), .opcode(opcode), .func3(func3), .func7(func7),
        .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .imme(imme),
        .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .busy(busy2), .done(done2), .err(err2), .count(count2),
        .dbg_state(dbg_state2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                         input logic [31:0] im);
        opcode   = op;
        func3    = f3;
        func7    = f7;
        Rs1      = r1;
        Rs2      = r2;
        Rd       = rd;
        imme     = im;
        in_valid = 1'b1;
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1; start = 1'b0; start2 = 1'b0; in_valid = 1'b0;
        opcode = '0; func3 = '0; func7 = 1'b0; Rs1 = '0; Rs2 = '0; Rd = '0; imme = '0;
        tick(); tick();
        rst = 1'b0; rst2 = 1'b0;
        #1;

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we",   32'(mem_we),   32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_err",      32'(err),      32'd0);
        check("rst_addr",     mem_addr,      32'h0);
        check("rst_wdata",    mem_wdata,     32'h0);
        check("rst_count",    32'(count),    32'd0);
        check("rst_state",    32'(dbg_state), 32'd0);
        check("rst2_addr",    mem_addr2,     32'h100);

        // Start a load
        start = 1'b1; tick(); start = 1'b0;
        check("start_busy",  32'(busy),     32'd1);
        check("start_ready", 32'(in_ready), 32'd1);

        // addi x1,x0,5
        drive(7'h13, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd5);
        tick(); in_valid = 1'b0;
        check("addi_we",    32'(mem_we),  32'd1);
        check("addi_addr",  mem_addr,     32'h0);
        check("addi_data",  mem_wdata,    32'h0050_0093);
        check("addi_count", 32'(count),   32'd1);

        // sw x2,8(x1) then beq x0,x0,-4 back to back
        drive(7'h23, 3'd2, 1'b0, 5'd1, 5'd2, 5'd0, 32'd8);
        tick();
        check("sw_we",   32'(mem_we), 32'd1);
        check("sw_addr", mem_addr,    32'h4);
        check("sw_data", mem_wdata,   32'h0020_A423);
        drive(7'h63, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
        tick(); in_valid = 1'b0;
        check("beq_we",    32'(mem_we), 32'd1);
        check("beq_addr",  mem_addr,    32'h8);
        check("beq_data",  mem_wdata,   32'hFE00_0EE3);
        check("beq_count", 32'(count),  32'd3);
        tick();
        check("idle_we",   32'(mem_we), 32'd0);
        check("hold_addr", mem_addr,    32'h8);
        check("hold_data", mem_wdata,   32'hFE00_0EE3);

        // ebreak
        drive(7'h73, 3'd0, 1'b0, 5'd3, 5'd4, 5'd5, 32'h1234);
        tick();
        check("ebrk_we",    32'(mem_we),   32'd1);
        check("ebrk_addr",  mem_addr,      32'hC);
        check("ebrk_data",  mem_wdata,     32'h0010_0073);
        check("ebrk_done",  32'(done),     32'd1);
        check("ebrk_count", 32'(count),    32'd4);
        check("ebrk_ready", 32'(in_ready), 32'd0);
        drive(7'h13, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd5);
        tick(); in_valid = 1'b0;
        check("after_done_we",    32'(mem_we), 32'd0);
        check("after_done_count", 32'(count),  32'd4);

        // Restart clears done and count
        start = 1'b1; tick(); start = 1'b0;
        check("restart_done",  32'(done),  32'd0);
        check("restart_count", 32'(count), 32'd0);
        check("restart_busy",  32'(busy),  32'd1);

        // srai x3,x3,2 then lui x5,0x12345000
        drive(7'h13, 3'd5, 1'b1, 5'd3, 5'd0, 5'd3, 32'd2);
        tick();
        check("srai_addr", mem_addr,  32'h0);
        check("srai_data", mem_wdata, 32'h4021_D193);
        drive(7'h37, 3'd0, 1'b0, 5'd0, 5'd0, 5'd5, 32'h1234_5000);
        tick(); in_valid = 1'b0;
        check("lui_addr",  mem_addr,   32'h4);
        check("lui_data",  mem_wdata,  32'h1234_52B7);
        check("lui_count", 32'(count), 32'd2);

        // jal with odd offset is rejected
        drive(7'h6F, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'h0000_0101);
        tick(); in_valid = 1'b0;
        check("jal_bad_we",    32'(mem_we),   32'd0);
        check("jal_bad_err",   32'(err),      32'd1);
        check("jal_bad_done",  32'(done),     32'd1);
        check("jal_bad_ready", 32'(in_ready), 32'd0);
        check("jal_bad_count", 32'(count),    32'd2);

        // start clears err; I-type immediate out of range is rejected
        start = 1'b1; tick(); start = 1'b0;
        check("clr_err", 32'(err), 32'd0);
        drive(7'h03, 3'd2, 1'b0, 5'd1, 5'd0, 5'd2, 32'h0000_0800);
        tick(); in_valid = 1'b0;
        check("ld_bad_we",  32'(mem_we), 32'd0);
        check("ld_bad_err", 32'(err),    32'd1);

        // Unknown opcode is rejected
        start = 1'b1; tick(); start = 1'b0;
        drive(7'h7F, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        tick(); in_valid = 1'b0;
        check("unk_err",  32'(err),  32'd1);
        check("unk_done", 32'(done), 32'd1);

        // Reset one cycle after an accept drops everything
        start = 1'b1; tick(); start = 1'b0;
        drive(7'h13, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd5);
        tick(); in_valid = 1'b0;
        check("pre_rst_we", 32'(mem_we), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("mid_rst_we",    32'(mem_we),  32'd0);
        check("mid_rst_count", 32'(count),   32'd0);
        check("mid_rst_busy",  32'(busy),    32'd0);
        check("mid_rst_addr",  mem_addr,     32'h0);
        check("mid_rst_data",  mem_wdata,    32'h0);

        // Capacity: MAX_WORDS=2, three valid addi offered
        start2 = 1'b1; tick(); start2 = 1'b0;
        drive(7'h13, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd5);
        tick();
        check("cap1_we",    32'(mem_we2), 32'd1);
        check("cap1_addr",  mem_addr2,    32'h100);
        check("cap1_count", 32'(count2),  32'd1);
        tick();
        check("cap2_we",    32'(mem_we2), 32'd1);
        check("cap2_addr",  mem_addr2,    32'h104);
        check("cap2_count", 32'(count2),  32'd2);
        check("cap2_done",  32'(done2),   32'd1);
        check("cap2_err",   32'(err2),    32'd0);
        tick(); in_valid = 1'b0;
        check("cap3_we",    32'(mem_we2), 32'd0);
        check("cap3_count", 32'(count2),  32'd2);
        check("cap3_err",   32'(err2),    32'd0);
        check("cap_main_idle_we", 32'(mem_we), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
